exec_muldiv: RTL and testbench
==============================

# exec_muldiv

Multi-cycle RV32M multiply/divide unit in the execute stage, fed by the decode-to-execute pipeline register alongside the main ALU. It accepts operands from the E stage and holds the pipeline through a stall output while it iterates. It returns one XLEN result that the execute-stage result mux forwards into the execute-to-memory register.

## Interface
Parameters:
- XLEN, 32, operand and result width.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  E-stage instruction is an M-extension op; sampled only in IDLE.
- op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a_i  in  XLEN  rs1 operand.
- b_i  in  XLEN  rs2 operand.
- flush_i  in  1  synchronous abort from the hazard unit.
- stall_o  out  1  hold PC, F/D and D/E registers (combinational).
- done_o  out  1  result_o valid this cycle (registered state).
- result_o  out  XLEN  result; holds its last value until the next DONE.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE with start_i=1 and no flush: latch op and operand magnitudes, record the result sign, clear the counter.
  - Fast case (div by zero, signed overflow): go to DONE.
  - Otherwise: go to CALC.
- CALC: one radix-2 step per cycle (shift-add multiply, restoring divide). The 5-bit counter counts 0..XLEN-1; after step XLEN-1, apply sign fix, write result_o and go to DONE.
- DONE: done_o=1, result_o valid; start_i ignored; unconditionally go to IDLE.
- stall_o = (IDLE & start_i & !flush_i) | CALC. It is low in DONE so the pipeline advances at the end of the DONE cycle.
- Arithmetic:
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN] with signed×signed, signed×unsigned and unsigned×unsigned operands respectively. Internal product is 2*XLEN wide.
  - Division by zero: quotient all ones (DIV and DIVU); remainder = a_i.
  - Signed overflow (DIV, a=0x8000_0000, b=0xFFFF_FFFF): quotient 0x8000_0000, remainder 0.
  - Signed remainder takes the sign of the dividend.
- flush_i in any state: go to IDLE next edge. done_o is not asserted and result_o is unchanged. flush_i has priority over start_i.
- Reset, asynchronous and allowed mid-operation: state IDLE, counter 0, result_o 0, done_o 0, all datapath registers 0.

## Timing
- Cycle n: start_i sampled high in IDLE, stall_o=1.
- Iterative ops: CALC during cycles n+1..n+XLEN, DONE in cycle n+XLEN+1 (n+33 for XLEN=32).
- Fast cases: DONE in cycle n+1.
- Back-to-back ops: next start_i is accepted in the IDLE cycle after DONE. Minimum issue interval is 2 cycles for fast cases and XLEN+2 otherwise.
- done_o is a one-cycle pulse.

## Configuration
- MULDIV_FAST_MUL_EN defined: multiply ops (op_i[2]=0) compute with a single-cycle 2*XLEN multiplier and go IDLE→DONE, so DONE is in cycle n+1. Division stays iterative.
- Undefined: multiply uses the iterative CALC path; no hardware multiplier is inferred.

## Structure
- Shared package muldiv_pkg:
  - typedef enum for op_i encodings.
  - typedef enum for FSM states.
  - Constants for the div-by-zero quotient and signed-overflow values.
- One sub-module, muldiv_step: combinational single-iteration shift-add/restoring-subtract datapath, instantiated once inside exec_muldiv.
- FSM, counter, sign handling and result register stay in the top.

## Test plan
- DIVU a=100, b=7 -> stall_o high cycles n..n+32, done_o in n+33, result_o=14; REMU same operands -> 2.
- DIV a=0x8000_0000, b=0xFFFF_FFFF -> done_o in n+1, result_o=0x8000_0000; REM same operands -> 0.
- DIV a=-7, b=0 -> done_o in n+1, result_o=0xFFFF_FFFF; REM a=-7, b=0 -> 0xFFFF_FFF9.
- MULH a=0xFFFF_FFFF, b=0xFFFF_FFFF -> result_o=0; MULHU same -> 0xFFFF_FFFE; MUL same -> 1.
  - With MULDIV_FAST_MUL_EN: done in n+1.
  - Without: done in n+33.
- DIV started, flush_i at cycle n+10 -> IDLE at n+11, no done_o, result_o unchanged.
- DIV started, rst_ni low at n+5 -> immediately IDLE, result_o=0, stall_o=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
//   - muldiv_op_e    : funct3 encodings of the M-extension ops
//   - muldiv_state_e : IDLE / CALC / DONE sequencing states
//   - special-case quotient/remainder values for divide-by-zero and signed overflow
//   - helpers that decode operand signedness and the sign of the final result
package muldiv_pkg;

    localparam int MULDIV_XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    localparam logic [MULDIV_XLEN-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam logic [MULDIV_XLEN-1:0] DIV_OVF_QUOT  = 32'h8000_0000;
    localparam logic [MULDIV_XLEN-1:0] DIV_OVF_REM   = 32'h0000_0000;

    // rs1 is interpreted as two's complement
    function automatic logic op_signed_a(input muldiv_op_e op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: op_signed_a = 1'b1;
            default:                            op_signed_a = 1'b0;
        endcase
    endfunction

    // rs2 is interpreted as two's complement
    function automatic logic op_signed_b(input muldiv_op_e op);
        case (op)
            OP_MULH, OP_DIV, OP_REM: op_signed_b = 1'b1;
            default:                 op_signed_b = 1'b0;
        endcase
    endfunction

    // Sign of the result computed from magnitudes; remainder follows the dividend.
    function automatic logic result_neg(input muldiv_op_e op, input logic a_msb, input logic b_msb);
        case (op)
            OP_MULH, OP_DIV:   result_neg = a_msb ^ b_msb;
            OP_MULHSU, OP_REM: result_neg = a_msb;
            default:           result_neg = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration on the {hi, lo} accumulator.
//   div_i  in  1        1 = restoring divide step, 0 = shift-add multiply step
//   acc_i  in  2*XLEN   multiply: {partial product, multiplier}; divide: {remainder, quotient/dividend}
//   opnd_i in  XLEN     multiplicand magnitude or divisor magnitude
//   acc_o  out 2*XLEN   accumulator after this step
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   partial_s;
    logic [XLEN-1:0] diff_s;
    logic            ge_s;

    // Single shift-add or restoring-subtract iteration
    always_comb begin
        // Multiply: add multiplicand when the multiplier LSB is set, then shift right with carry.
        mul_sum_s = {1'b0, acc_i[2*XLEN-1:XLEN]} +
                    (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
        // Divide: shift the next dividend bit into the remainder and trial-subtract.
        partial_s = acc_i[2*XLEN-1:XLEN-1];
        ge_s      = (partial_s >= {1'b0, opnd_i});
        // When ge_s the true difference is below the divisor, so XLEN bits hold it exactly.
        diff_s    = partial_s[XLEN-1:0] - opnd_i;
        if (div_i) begin
            acc_o = {(ge_s ? diff_s : partial_s[XLEN-1:0]), acc_i[XLEN-2:0], ge_s};
        end else begin
            acc_o = {mul_sum_s, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/exec_muldiv.sv
// exec_muldiv: multi-cycle RV32M multiply/divide unit for the execute stage.
//   clk_i    in   1     clock, rising edge
//   rst_ni   in   1     asynchronous active-low reset
//   start_i  in   1     M-extension op present in E (sampled in IDLE only)
//   op_i     in   3     funct3 (MUL..REMU)
//   a_i/b_i  in   XLEN  rs1 / rs2 operands
//   flush_i  in   1     synchronous abort, overrides start_i
//   stall_o  out  1     hold the front of the pipeline while busy
//   done_o   out  1     one-cycle pulse, result_o valid
//   result_o out  XLEN  last completed result
// Optional build macro MULDIV_FAST_MUL_EN: multiplies finish in one cycle on a
// full-width multiplier; division stays iterative.
module exec_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int               CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    muldiv_op_e        op_in_s;
    logic              is_div_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s;
    logic              ovf_s, fast_div_s;
    logic [XLEN-1:0]   fast_div_res_s;
    logic              fast_mul_s;
    logic [XLEN-1:0]   fast_mul_res_s;
    logic [2*XLEN-1:0] step_acc_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   div_word_s;
    logic [XLEN-1:0]   calc_res_s;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_i  (op_q[2]),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc_s)
    );

    // Operand decode: magnitudes and single-cycle divide special cases
    always_comb begin
        op_in_s  = muldiv_op_e'(op_i);
        is_div_s = op_i[2];
        a_mag_s  = (op_signed_a(op_in_s) && a_i[XLEN-1]) ? -a_i : a_i;
        b_mag_s  = (op_signed_b(op_in_s) && b_i[XLEN-1]) ? -b_i : b_i;
        ovf_s    = ((op_in_s == OP_DIV) || (op_in_s == OP_REM)) &&
                   (a_i == DIV_OVF_QUOT) && (b_i == {XLEN{1'b1}});
        fast_div_s = is_div_s && ((b_i == {XLEN{1'b0}}) || ovf_s);
        // op_i[1] separates REM/REMU from DIV/DIVU
        if (ovf_s) begin
            fast_div_res_s = op_i[1] ? DIV_OVF_REM : DIV_OVF_QUOT;
        end else begin
            fast_div_res_s = op_i[1] ? a_i : DIV_ZERO_QUOT;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] a_ext_s, b_ext_s, full_prod_s;

    // Single-cycle multiply on sign- or zero-extended operands
    always_comb begin
        a_ext_s = op_signed_a(op_in_s) ? {{XLEN{a_i[XLEN-1]}}, a_i} : {{XLEN{1'b0}}, a_i};
        b_ext_s = op_signed_b(op_in_s) ? {{XLEN{b_i[XLEN-1]}}, b_i} : {{XLEN{1'b0}}, b_i};
        full_prod_s    = a_ext_s * b_ext_s;
        fast_mul_s     = ~op_i[2];
        fast_mul_res_s = (op_in_s == OP_MUL) ? full_prod_s[XLEN-1:0] : full_prod_s[2*XLEN-1:XLEN];
    end
`else
    // Multiplies always iterate in this build
    always_comb begin
        fast_mul_s     = 1'b0;
        fast_mul_res_s = {XLEN{1'b0}};
    end
`endif

    // Sign fix of the final iteration's accumulator
    always_comb begin
        prod_fix_s = neg_q ? -step_acc_s : step_acc_s;
        div_word_s = op_q[1] ? step_acc_s[2*XLEN-1:XLEN] : step_acc_s[XLEN-1:0];
        if (op_q[2]) begin
            calc_res_s = neg_q ? -div_word_s : div_word_s;
        end else begin
            calc_res_s = (op_q == OP_MUL) ? prod_fix_s[XLEN-1:0] : prod_fix_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state and datapath update; flush wins over everything
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        op_d   = op_in_s;
                        cnt_d  = {CNT_W{1'b0}};
                        neg_d  = result_neg(op_in_s, a_i[XLEN-1], b_i[XLEN-1]);
                        // Multiplier or dividend sits in the low half, the other operand in opnd.
                        acc_d  = {{XLEN{1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
                        opnd_d = is_div_s ? b_mag_s : a_mag_s;
                        if (fast_div_s) begin
                            result_d = fast_div_res_s;
                            state_d  = ST_DONE;
                        end else if (fast_mul_s) begin
                            result_d = fast_mul_res_s;
                            state_d  = ST_DONE;
                        end else begin
                            state_d = ST_CALC;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    acc_d = step_acc_s;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        result_d = calc_res_s;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= {(2*XLEN){1'b0}};
            opnd_q   <= {XLEN{1'b0}};
            neg_q    <= 1'b0;
            result_q <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign stall_o  = ((state_q == ST_IDLE) && start_i && !flush_i) || (state_q == ST_CALC);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_exec_muldiv.sv
// tb_exec_muldiv: table-driven, scoreboarded bench for exec_muldiv, plus
// hand-written flush, flush-on-start and mid-operation reset sequences.
module tb_exec_muldiv;

    localparam int IT = 33;
`ifdef MULDIV_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = 33;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_exp;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    exec_muldiv #(.XLEN(32)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Entered #1 after a rising edge with the DUT in IDLE; returns #1 into the
    // IDLE cycle that follows DONE, so consecutive calls issue back-to-back.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int  stalls;
        bit  seen;
        stalls  = 0;
        seen    = 1'b0;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        sb_q.push_back(exp);
        last_exp = exp;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) begin
                check({name, "_latency"}, k, lat);
                check({name, "_result"}, result_o, sb_q.pop_front());
                check({name, "_stall_in_done"}, {31'd0, stall_o}, 32'd0);
                seen = 1'b1;
            end else if (stall_o === 1'b1) begin
                stalls++;
            end
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            if (seen) break;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: actual=no done_o required=done_o within 40 cycles", name);
            void'(sb_q.pop_front());
        end
        check({name, "_stall_cycles"}, stalls, lat);
    endtask

    initial begin
        bit done_seen;

        vecs[0]  = '{3'd5, 32'd100,        32'd7,          32'd14,         IT};
        vecs[1]  = '{3'd7, 32'd100,        32'd7,          32'd2,          IT};
        vecs[2]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[3]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  1};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'h0000_0000,  32'hFFFF_FFFF,  1};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'h0000_0000,  32'hFFFF_FFF9,  1};
        vecs[6]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  ML};
        vecs[7]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  ML};
        vecs[8]  = '{3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  ML};
        vecs[9]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  IT};
        vecs[10] = '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  IT};
        vecs[11] = '{3'd5, 32'd0,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[12] = '{3'd7, 32'd5,          32'd0,          32'd5,          1};
        vecs[13] = '{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  ML};
        vecs[14] = '{3'd0, 32'd12345,      32'd1000,       32'h00BC_5EA8,  ML};
        vecs[15] = '{3'd4, 32'd20,         32'hFFFF_FFFA,  32'hFFFF_FFFD,  IT};
        vecs[16] = '{3'd6, 32'd20,         32'hFFFF_FFFA,  32'd2,          IT};
        vecs[17] = '{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  ML};
        vecs[18] = '{3'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  ML};
        vecs[19] = '{3'd5, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  IT};

        rst_ni  = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = 3'd0;
        a_i     = 32'd0;
        b_i     = 32'd0;
        repeat (3) @(negedge clk_i);
        check("reset_result", result_o, 32'd0);
        check("reset_done", {31'd0, done_o}, 32'd0);
        check("reset_stall", {31'd0, stall_o}, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 20; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Flush in the middle of a divide: no done, result unchanged
        op_i = 3'd4; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_stall_calc", {31'd0, stall_o}, 32'd1);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        check("flush_idle_stall", {31'd0, stall_o}, 32'd0);
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) done_seen = 1'b1;
        end
        check("flush_no_done", {31'd0, done_seen}, 32'd0);
        check("flush_result_kept", result_o, last_exp);

        // Flush together with start: not accepted, no stall
        @(posedge clk_i);
        #1;
        op_i = 3'd5; a_i = 32'd9; b_i = 32'd3; start_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_start_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i);
        #1;
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        check("flush_start_not_busy", {31'd0, stall_o}, 32'd0);
        @(negedge clk_i);
        check("flush_start_no_done", {31'd0, done_o}, 32'd0);

        // Asynchronous reset in the middle of a divide
        @(posedge clk_i);
        #1;
        op_i = 3'd4; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_result", result_o, 32'd0);
        check("rst_mid_stall", {31'd0, stall_o}, 32'd0);
        check("rst_mid_done", {31'd0, done_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        run_op("after_reset", 3'd5, 32'd1000, 32'd10, 32'd100, IT);

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=still running required=finished");
        $fatal(1, "bench timeout");
    end

endmodule
